json_cmd_rx: RTL and testbench

Receive-side counterpart of the rover's JSON drive-command UART link. Deserialises 8N1 UART bytes from a GPIO pin and parses frames of the form {"T":d,"L":[-]i.f,"R":[-]i.f} followed by '\n'. Decoded wheel commands are presented as a latched, one-cycle-strobed result. It sits on the rover/bridge side of the link, or loops back in the FPGA testbench, to check what the command transmitter emits.

---
 rtl/json_link_pkg.sv | 38 +++
 rtl/uart_rx.sv | 85 ++++++++
 rtl/json_cmd_rx.sv | 133 +++++++++++++
 tb/tb_json_cmd_rx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/json_link_pkg.sv
// json_link_pkg: parser states, ASCII constants and wheel command type
// shared by the JSON drive-command transmitter and receiver.
package json_link_pkg;

    typedef enum logic [3:0] {
        P_IDLE, P_HDR, P_T, P_LKEY, P_LSGN, P_LINT, P_LDOT, P_LFRAC,
        P_RKEY, P_RSGN, P_RINT, P_RDOT, P_RFRAC, P_CLOSE, P_EOL
    } pstate_e;

    typedef struct packed {
        logic       neg;
        logic [3:0] tenths;
    } wheel_cmd_t;

    localparam logic [7:0] CH_LBRACE = 8'h7B;
    localparam logic [7:0] CH_RBRACE = 8'h7D;
    localparam logic [7:0] CH_QUOTE  = 8'h22;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_MINUS  = 8'h2D;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_ZERO   = 8'h30;

    function automatic logic is_digit(input logic [7:0] c);
        return c >= CH_ZERO && c <= 8'h39;
    endfunction

    // Key strings are "T": after the brace, ,"L": and ,"R": before each value.
    function automatic logic [7:0] key_char(input pstate_e s, input logic [2:0] i);
        logic [2:0] j;
        logic [7:0] letter;
        j = (s == P_HDR) ? i + 3'd1 : i;
        letter = (s == P_HDR) ? 8'h54 : (s == P_LKEY) ? 8'h4C : 8'h52;
        return (j == 3'd0) ? CH_COMMA : (j == 3'd2) ? letter : (j == 3'd4) ? CH_COLON : CH_QUOTE;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with a 2-flop synchroniser, glitch-rejecting start
// check, one-cycle byte strobe and a one-cycle stop-bit error pulse.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       err_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_e;

    rstate_e       state_q, state_d;
    logic [2:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d, err_q, err_d, rxs;

    // sync_q[1] is the synchronised line, sync_q[2] its previous value for edge detect
    assign rxs = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q + 1'b1;
        bit_d = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        err_d = 1'b0;
        case (state_q)
            R_IDLE: begin
                cnt_d = '0;
                if (sync_q[2] && !rxs) state_d = R_START;
            end
            R_START: if (cnt_q == HALF) begin
                cnt_d = '0;
                bit_d = '0;
                state_d = rxs ? R_IDLE : R_DATA;
            end
            R_DATA: if (cnt_q == FULL) begin
                cnt_d = '0;
                shift_d = {rxs, shift_q[7:1]};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = R_STOP;
            end
            R_STOP: if (cnt_q == FULL) begin
                state_d = R_IDLE;
                valid_d = rxs;
                err_d = !rxs;
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= R_IDLE;
            sync_q <= 3'b111;
            cnt_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q <= {sync_q[1:0], rx_i};
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            err_q <= err_d;
        end
    end

    assign data_o = shift_q;
    assign valid_o = valid_q;
    assign err_o = err_q;

endmodule

// File: rtl/json_cmd_rx.sv
// json_cmd_rx: receives {"T":d,"L":[-]i.f,"R":[-]i.f}\n frames over UART and
// presents the decoded wheel command as a latched, one-cycle-strobed result.
module json_cmd_rx
    import json_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_in,
    output logic       frame_valid,
    output logic       frame_err,
    output logic [3:0] cmd_type,
    output logic       left_neg,
    output logic [3:0] left_tenths,
    output logic       right_neg,
    output logic [3:0] right_tenths
);
    logic [7:0] b;
    logic       rx_vld, rx_err;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk    (clk),
        .rst    (rst),
        .rx_i   (uart_in),
        .data_o (b),
        .valid_o(rx_vld),
        .err_o  (rx_err)
    );

    pstate_e    st_q, st_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] t_q, t_d, out_t_q, nxt;
    wheel_cmd_t l_q, l_d, r_q, r_d, w_q, w_d, out_l_q, out_r_q;
    logic       valid_q, valid_d, err_q, err_d, bad, right, sgn;

    // Left and right value states share one datapath; w_q is the wheel being parsed.
    always_comb begin
        right = st_q >= P_RKEY && st_q <= P_RFRAC;
        sgn = st_q == P_LSGN || st_q == P_RSGN;
        w_q = right ? r_q : l_q;
        w_d = w_q;
        nxt = st_q + 4'd1;
        st_d = st_q;
        idx_d = (rx_vld || rx_err) ? 3'd0 : idx_q;
        t_d = t_q;
        valid_d = 1'b0;
        err_d = 1'b0;
        bad = 1'b0;
        if (rx_err) begin
            st_d = P_IDLE;
            err_d = 1'b1;
        end else if (rx_vld) begin
            case (st_q)
                P_IDLE: if (b == CH_LBRACE) st_d = P_HDR;
                P_HDR, P_LKEY, P_RKEY:
                    if (b != key_char(st_q, idx_q)) bad = 1'b1;
                    else if (idx_q == (st_q == P_HDR ? 3'd3 : 3'd4)) st_d = pstate_e'(nxt);
                    else idx_d = idx_q + 3'd1;
                P_T:
                    if (is_digit(b)) begin
                        t_d = b[3:0];
                        st_d = pstate_e'(nxt);
                    end else bad = 1'b1;
                P_LSGN, P_RSGN, P_LINT, P_RINT:
                    if (sgn && b == CH_MINUS) begin
                        w_d.neg = 1'b1;
                        st_d = pstate_e'(nxt);
                    end else if (b[7:1] == CH_ZERO[7:1]) begin
                        w_d.neg = sgn ? 1'b0 : w_q.neg;
                        w_d.tenths = b[0] ? 4'd10 : 4'd0;
                        st_d = pstate_e'(sgn ? nxt + 4'd1 : nxt);
                    end else bad = 1'b1;
                P_LDOT, P_RDOT: if (b == CH_DOT) st_d = pstate_e'(nxt); else bad = 1'b1;
                P_LFRAC, P_RFRAC:
                    if (is_digit(b) && !(w_q.tenths[3] && b[3:0] != 4'd0)) begin
                        w_d.tenths = w_q.tenths + b[3:0];
                        st_d = pstate_e'(nxt);
                    end else bad = 1'b1;
                P_CLOSE: if (b == CH_RBRACE) st_d = P_EOL; else bad = 1'b1;
                P_EOL:
                    if (b == CH_LF) begin
                        st_d = P_IDLE;
                        valid_d = 1'b1;
                    end else bad = 1'b1;
                default: st_d = P_IDLE;
            endcase
            if (bad) begin
                st_d = (b == CH_LBRACE) ? P_HDR : P_IDLE;
                err_d = 1'b1;
            end
        end
        l_d = right ? l_q : w_d;
        r_d = right ? w_d : r_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q <= P_IDLE;
            idx_q <= '0;
            t_q <= '0;
            l_q <= '0;
            r_q <= '0;
            out_t_q <= '0;
            out_l_q <= '0;
            out_r_q <= '0;
            valid_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            st_q <= st_d;
            idx_q <= idx_d;
            t_q <= t_d;
            l_q <= l_d;
            r_q <= r_d;
            valid_q <= valid_d;
            err_q <= err_d;
            if (valid_d) begin
                out_t_q <= t_q;
                out_l_q <= l_q;
                out_r_q <= r_q;
            end
        end
    end

    assign frame_valid = valid_q;
    assign frame_err = err_q;
    assign cmd_type = out_t_q;
    assign left_neg = out_l_q.neg;
    assign left_tenths = out_l_q.tenths;
    assign right_neg = out_r_q.neg;
    assign right_tenths = out_r_q.tenths;

endmodule

// File: tb/tb_json_cmd_rx.sv
// tb_json_cmd_rx: directed UART frames checked against a string-level
// grammar model of the drive-command link.
`timescale 1ns/1ps
module tb_json_cmd_rx;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_in = 1'b1;
    logic frame_valid, frame_err, left_neg, right_neg;
    logic [3:0] cmd_type, left_tenths, right_tenths;
    logic [13:0] outs;

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid = 0;
    int n_err = 0;

    typedef struct {
        bit          err;
        logic [13:0] v;
    } ev_t;
    ev_t evq[$];
    logic [13:0] exp_v = '0;
    string mbuf = "";

    always #5 clk = ~clk;

    json_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_in     (uart_in),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .cmd_type    (cmd_type),
        .left_neg    (left_neg),
        .left_tenths (left_tenths),
        .right_neg   (right_neg),
        .right_tenths(right_tenths)
    );

    assign outs = {cmd_type, left_neg, left_tenths, right_neg, right_tenths};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [13:0] pk(input int t, input bit ln, input int lt, input bit rn, input int rt);
        return {4'(t), ln, 4'(lt), rn, 4'(rt)};
    endfunction

    // Grammar template: d digit, s optional '-', v integer 0/1, f fraction digit.
    function automatic bit prefix_ok(input string s);
        string tpl = "{\"T\":d,\"L\":sv.f,\"R\":sv.f}\n";
        int j = 0;
        for (int i = 0; i < s.len(); i++) begin
            byte c = s[i];
            if (j >= tpl.len()) return 0;
            if (tpl[j] == "s") begin
                j++;
                if (c == "-") continue;
            end
            case (tpl[j])
                "d", "f": if (c < "0" || c > "9") return 0;
                "v": if (c != "0" && c != "1") return 0;
                default: if (c != tpl[j]) return 0;
            endcase
            if (tpl[j] == "f" && c != "0" && s[i-2] == "1") return 0;
            j++;
        end
        return 1;
    endfunction

    function automatic logic [4:0] wheel_at(input string s, input int p);
        bit n = (s[p] == "-");
        int q = p + int'(n);
        return {n, 4'(10 * (s[q] - "0") + (s[q+2] - "0"))};
    endfunction

    function automatic logic [13:0] decode(input string s);
        int rp = 12;
        while (s[rp] != "R") rp++;
        return {4'(s[5] - "0"), wheel_at(s, 11), wheel_at(s, rp + 3)};
    endfunction

    task automatic model_byte(input byte b, input bit stop);
        ev_t e;
        if (!stop) begin
            e.err = 1;
            e.v = '0;
            evq.push_back(e);
            mbuf = "";
            return;
        end
        if (mbuf.len() == 0) begin
            if (b == "{") mbuf = "{";
            return;
        end
        mbuf = $sformatf("%s%c", mbuf, b);
        if (!prefix_ok(mbuf)) begin
            e.err = 1;
            e.v = '0;
            evq.push_back(e);
            mbuf = (b == "{") ? "{" : "";
        end else if (b == "\n") begin
            e.err = 0;
            e.v = decode(mbuf);
            evq.push_back(e);
            mbuf = "";
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        model_byte(byte'(b), stop);
        uart_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_in = stop;
        repeat (CPB) @(negedge clk);
        if (!stop) begin
            uart_in = 1'b1;
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            exp_v = '0;
            check("reset_outputs", {16'd0, frame_valid, frame_err, outs}, 32'd0);
        end else begin
            if (frame_valid || frame_err) begin
                n_valid += int'(frame_valid);
                n_err += int'(frame_err);
                if (evq.size() == 0) check("unexpected_pulse", {30'd0, frame_valid, frame_err}, 32'd0);
                else begin
                    e = evq.pop_front();
                    check("pulse_kind", {30'd0, frame_valid, frame_err}, e.err ? 32'd1 : 32'd2);
                    if (!e.err) exp_v = e.v;
                end
            end
            check("held_outputs", {18'd0, outs}, {18'd0, exp_v});
        end
    end

    initial begin
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        check("lit_reset_state", {18'd0, outs}, 32'd0);
        #2 rst = 1'b1;
        repeat (4 * CPB) @(negedge clk);

        send_str("ab{\"T\":1,\"L\":0.5,\"R\":0.5}\n");
        repeat (2 * CPB) @(negedge clk);
        check("lit_t1_outputs", {18'd0, outs}, {18'd0, pk(1, 0, 5, 0, 5)});
        check("lit_t1_valid_cnt", n_valid, 1);
        check("lit_t1_err_cnt", n_err, 0);

        send_str("{\"T\":1,\"L\":-0.3,\"R\":0.3}\n");
        check("lit_t2a_outputs", {18'd0, outs}, {18'd0, pk(1, 1, 3, 0, 3)});
        send_str("{\"T\":1,\"L\":0.7,\"R\":-0.7}\n");
        repeat (2 * CPB) @(negedge clk);
        check("lit_t2b_outputs", {18'd0, outs}, {18'd0, pk(1, 0, 7, 1, 7)});
        check("lit_t2_valid_cnt", n_valid, 3);

        send_str("{\"T\":1,\"L\":1.0,\"R\":-1.0}\n");
        repeat (2 * CPB) @(negedge clk);
        check("lit_t3_full_scale", {18'd0, outs}, {18'd0, pk(1, 0, 10, 1, 10)});
        send_str("{\"T\":1,\"L\":1.2,\"R\":0.0}\n");
        repeat (2 * CPB) @(negedge clk);
        check("lit_t3_held", {18'd0, outs}, {18'd0, pk(1, 0, 10, 1, 10)});
        check("lit_t3_err_cnt", n_err, 1);

        send_str("{\"T\":1,\"L");
        send_byte(":", 1'b0);
        send_str("{\"T\":3,\"L\":0.0,\"R\":-0.1}\n");
        repeat (2 * CPB) @(negedge clk);
        check("lit_t4_outputs", {18'd0, outs}, {18'd0, pk(3, 0, 0, 1, 1)});
        check("lit_t4_err_cnt", n_err, 2);

        send_str("{\"T\":1,\"L\":{\"T\":1,\"L\":0.2,\"R\":0.4}\n");
        repeat (2 * CPB) @(negedge clk);
        check("lit_t5_resync", {18'd0, outs}, {18'd0, pk(1, 0, 2, 0, 4)});
        check("lit_t5_err_cnt", n_err, 3);
        check("lit_t5_valid_cnt", n_valid, 6);

        send_str("{\"X\"");
        repeat (2 * CPB) @(negedge clk);
        check("lit_hdr_err_cnt", n_err, 4);

        uart_in = 1'b0;
        repeat (5) @(negedge clk);
        uart_in = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("lit_glitch_err_cnt", n_err, 4);
        check("lit_glitch_valid_cnt", n_valid, 6);

        send_str("{\"T\":7,\"L\":");
        uart_in = 1'b0;
        repeat (3 * CPB + 3) @(negedge clk);
        #2 rst = 1'b0;
        mbuf = "";
        evq.delete();
        uart_in = 1'b1;
        repeat (5) @(negedge clk);
        check("lit_mid_reset", {18'd0, outs}, 32'd0);
        #2 rst = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("lit_post_reset", {18'd0, outs}, 32'd0);
        send_str("{\"T\":9,\"L\":-0.9,\"R\":1.0}\n");
        repeat (2 * CPB) @(negedge clk);
        check("lit_t6_outputs", {18'd0, outs}, {18'd0, pk(9, 1, 9, 0, 10)});
        check("lit_t6_valid_cnt", n_valid, 7);
        check("lit_t6_err_cnt", n_err, 4);

        check("events_drained", evq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
